// File: rtl/uart_8n1_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Optional line-break generation is enabled with `define UART_TX_BREAK_EN.
module uart_8n1_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk_baud_16x,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 send_write,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 send_ready,
  output logic                 send_busy,
  output logic                 tx
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BRK,
    S_BRK_GAP
`endif
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_valid, w_hold_valid_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_accept, w_load, w_cnt_last, w_brk;

`ifdef UART_TX_BREAK_EN
  assign w_brk = send_break;
`else
  assign w_brk = 1'b0;
`endif

  assign w_accept   = send_write & ~r_hold_valid;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_brk) begin
`ifdef UART_TX_BREAK_EN
          w_state_nxt = S_BRK;
`endif
        end else if (r_hold_valid) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) w_state_nxt = S_STOP;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
      end
      S_STOP: begin
        // A queued byte chains straight into its start bit unless a break is pending.
        if (w_cnt_last) begin
          w_cnt_nxt = '0;
          if (r_hold_valid && !w_brk) begin
            w_state_nxt = S_START;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        w_cnt_nxt = '0;
        if (!send_break) w_state_nxt = S_BRK_GAP;
      end
      S_BRK_GAP: begin
        if (w_cnt_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_shift_nxt      = w_load ? r_hold : r_shift;
    w_hold_valid_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_valid);

    // tx is registered from the next state so the line changes on the same edge as the state.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[w_idx_nxt];
`ifdef UART_TX_BREAK_EN
      S_BRK:   w_tx_nxt = 1'b0;
`endif
      default: w_tx_nxt = 1'b1;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) | w_hold_valid_nxt;
  end

  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      if (w_accept) r_hold <= send_data;
    end
  end

  assign send_ready = ~r_hold_valid;
  assign send_busy  = r_busy;
  assign tx         = r_tx;

endmodule
